bfp_shift_ctrl: RTL and testbench
=================================

Name: bfp_shift_ctrl

Overview:
- Block-floating-point shift controller for the acquisition engine.
- Observes one block of unsigned magnitudes from the coherent/non-coherent accumulator.
- At block end, computes the minimum biased-rounding shift count (0..10) that brings the block peak into OUT_WIDTH bits. This count drives the downstream 10-bit round-shift scaler, so this block is the producer of its shift_bit control.
- Also keeps a saturating running exponent so software can rebuild absolute power.

Parameters:
DATA_WIDTH, 20, width of incoming magnitude samples
OUT_WIDTH, 10, target width after round shift
LEN_WIDTH, 10, width of block length field
EXP_WIDTH, 8, width of accumulated exponent

Ports:
clk  input  1  clock
rst_b  input  1  asynchronous active-low reset
block_start  input  1  one-cycle pulse, starts a block (honoured only in IDLE)
block_len  input  LEN_WIDTH  samples per block, sampled on block_start; 0 means 2^LEN_WIDTH
data_valid  input  1  data_in qualifier
data_in  input  DATA_WIDTH  unsigned magnitude sample
exp_clear  input  1  clears exp_acc
busy  output  1  high in COLLECT and CALC
shift_valid  output  1  one-cycle pulse, shift_bit updated
shift_bit  output  4  computed shift, held until next update
exp_acc  output  EXP_WIDTH  saturating sum of issued shift_bit
overflow  output  1  sticky; peak does not fit even at shift 10; cleared by exp_clear

Behaviour:
- Reset (rst_b low, async): state IDLE; busy=0, shift_valid=0, shift_bit=0, exp_acc=0, overflow=0; peak=0, sample counter=0.
- FSM states: IDLE, COLLECT, CALC.
- IDLE:
  - block_start: latch block_len, clear peak and counter, go to COLLECT.
  - data_valid is ignored.
- COLLECT:
  - On data_valid: peak <= max(peak, data_in); counter++.
  - When the accepted sample is number block_len, go to CALC on the next edge.
  - block_start is ignored while busy.
- CALC (exactly one cycle):
  - fits(s) = ((peak >> s) + (s>0 ? peak[s-1] : 0)) <= 2^OUT_WIDTH-1.
  - shift = smallest s in 0..10 with fits(s). If none fits, shift=10 and overflow is set.
  - Register shift_bit; pulse shift_valid for one cycle; return to IDLE.
- Timing:
  - Last sample accepted at edge T; CALC is active in the cycle after T.
  - shift_valid and the new shift_bit are visible after edge T+2.
  - A new block_start is accepted in the cycle shift_valid is high (state already IDLE).
- exp_acc:
  - On shift_valid, exp_acc <= min(exp_acc + shift_bit, 2^EXP_WIDTH-1).
  - exp_clear alone: exp_acc <= 0 and overflow <= 0.
  - exp_clear in the same cycle as an update: exp_acc <= shift_bit (clear first, then add), and overflow takes the new block's value.
- Arithmetic: peak compare is unsigned at DATA_WIDTH. The fits() add uses OUT_WIDTH+1 bits or more, so the rounding carry is never lost.
- Peak of 0: shift_bit=0.
- block_len=0: the block lasts 1024 samples (for LEN_WIDTH=10).
- rst_b asserted mid-block: immediate return to reset values; no shift_valid is issued for the aborted block.

Test Plan:
- block_len=4, samples 100,1023,7,0 → shift_valid 2 cycles after the 4th sample; shift_bit=0; exp_acc=0.
- block_len=2, samples 1024,3 → 1024>>1=512, fits → shift_bit=1; exp_acc=1.
- block_len=1, sample 2047 → s=1 gives 1023+1=1024 (no fit); s=2 gives 511+1=512 → shift_bit=2.
- block_len=1, sample 20'hFFFFF → s=10 gives 1023+1=1024 (no fit) → shift_bit=10, overflow=1. Then exp_clear → overflow=0, exp_acc=0.
- Run 30 blocks each yielding shift 10 → exp_acc saturates at 255. exp_clear coincident with a shift_valid carrying 3 → exp_acc=3.
- Gaps in data_valid plus block_start pulses during COLLECT → the extra pulses are ignored and the sample count is unchanged. Assert rst_b mid-block → all outputs 0 and no shift_valid.

Source files
------------

// File: rtl/bfp_shift_ctrl_if.sv
// Block-floating-point shift controller bus: sample stream in, shift control and exponent out.
// The master drives the samples and block control; the slave is the controller.
interface bfp_shift_ctrl_if #(
  parameter int DATA_WIDTH = 20,
  parameter int LEN_WIDTH  = 10,
  parameter int EXP_WIDTH  = 8
) ();
  logic                  block_start;
  logic [LEN_WIDTH-1:0]  block_len;
  logic                  data_valid;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  exp_clear;
  logic                  busy;
  logic                  shift_valid;
  logic [3:0]            shift_bit;
  logic [EXP_WIDTH-1:0]  exp_acc;
  logic                  overflow;

  modport master (
    output block_start, block_len, data_valid, data_in, exp_clear,
    input  busy, shift_valid, shift_bit, exp_acc, overflow
  );

  modport slave (
    input  block_start, block_len, data_valid, data_in, exp_clear,
    output busy, shift_valid, shift_bit, exp_acc, overflow
  );
endinterface

// File: rtl/bfp_shift_ctrl.sv
// Tracks the peak magnitude of a block and issues the smallest round-shift (0..10)
// that fits it into OUT_WIDTH bits, plus a saturating running exponent.
module bfp_shift_ctrl #(
  parameter int DATA_WIDTH = 20,
  parameter int OUT_WIDTH  = 10,
  parameter int LEN_WIDTH  = 10,
  parameter int EXP_WIDTH  = 8
) (
  input logic              clk,
  input logic              rst_b,
  bfp_shift_ctrl_if.slave  bus
);

  localparam int MAX_SHIFT = 10;
  localparam int CNT_W     = LEN_WIDTH + 1;
  localparam logic [DATA_WIDTH:0] FIT_MAX = (DATA_WIDTH+1)'((1 << OUT_WIDTH) - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, CALC} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] peak;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      target;
  logic                  last_smp;
  logic [3:0]            shift_calc;
  logic                  ovf_calc;
  logic                  vld_p0;
  logic [3:0]            shift_p0;
  logic                  ovf_p0;
  logic                  shift_valid_q;
  logic [3:0]            shift_bit_q;
  logic                  blk_ovf_q;
  logic [EXP_WIDTH-1:0]  exp_acc_q;
  logic                  overflow_q;

  // Returns {overflow, shift}: smallest s whose rounded peak fits, else MAX_SHIFT with overflow.
  function automatic logic [4:0] calc_shift(input logic [DATA_WIDTH-1:0] pk);
    logic [DATA_WIDTH:0] rnd;
    logic [3:0]          sh;
    logic                found;
    sh    = 4'(MAX_SHIFT);
    found = 1'b0;
    for (int s = MAX_SHIFT; s >= 1; s--) begin
      rnd = {1'b0, pk >> s} + (DATA_WIDTH+1)'(pk[s-1]);
      if (rnd <= FIT_MAX) begin
        sh    = 4'(s);
        found = 1'b1;
      end
    end
    if ({1'b0, pk} <= FIT_MAX) begin
      sh    = 4'd0;
      found = 1'b1;
    end
    return {~found, sh};
  endfunction

  function automatic logic [EXP_WIDTH-1:0] sat_add(input logic [EXP_WIDTH-1:0] a,
                                                   input logic [3:0]           b);
    logic [EXP_WIDTH:0] sum;
    sum = {1'b0, a} + (EXP_WIDTH+1)'(b);
    return sum[EXP_WIDTH] ? {EXP_WIDTH{1'b1}} : sum[EXP_WIDTH-1:0];
  endfunction

  assign last_smp = ((cnt + CNT_W'(1)) == target);
  assign {ovf_calc, shift_calc} = calc_shift(peak);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.block_start)              state_nxt = COLLECT;
      COLLECT: if (bus.data_valid && last_smp)   state_nxt = CALC;
      CALC:                                      state_nxt = IDLE;
      default:                                   state_nxt = IDLE;
    endcase
  end

  // Collect stage: block_len of 0 maps to 2^LEN_WIDTH via the extra top bit.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      peak   <= '0;
      cnt    <= '0;
      target <= '0;
    end else if (state == IDLE && bus.block_start) begin
      peak   <= '0;
      cnt    <= '0;
      target <= {(bus.block_len == '0), bus.block_len};
    end else if (state == COLLECT && bus.data_valid) begin
      if (bus.data_in > peak) peak <= bus.data_in;
      cnt <= cnt + CNT_W'(1);
    end
  end

  // p0: shift computed during CALC
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) vld_p0 <= 1'b0;
    else        vld_p0 <= (state == CALC);
  end

  always_ff @(posedge clk) begin
    shift_p0 <= shift_calc;
    ovf_p0   <= ovf_calc;
  end

  // p1: issued shift and its block overflow flag
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      shift_valid_q <= 1'b0;
      shift_bit_q   <= '0;
      blk_ovf_q     <= 1'b0;
    end else begin
      shift_valid_q <= vld_p0;
      if (vld_p0) begin
        shift_bit_q <= shift_p0;
        blk_ovf_q   <= ovf_p0;
      end
    end
  end

  // p2: exponent and sticky overflow; a coincident clear acts before the add
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      exp_acc_q  <= '0;
      overflow_q <= 1'b0;
    end else if (shift_valid_q) begin
      exp_acc_q  <= bus.exp_clear ? EXP_WIDTH'(shift_bit_q) : sat_add(exp_acc_q, shift_bit_q);
      overflow_q <= bus.exp_clear ? blk_ovf_q : (overflow_q | blk_ovf_q);
    end else if (bus.exp_clear) begin
      exp_acc_q  <= '0;
      overflow_q <= 1'b0;
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.shift_valid = shift_valid_q;
  assign bus.shift_bit   = shift_bit_q;
  assign bus.exp_acc     = exp_acc_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_bfp_shift_ctrl.sv
// Self-checking bench for bfp_shift_ctrl: vector table plus hand-written corner sequences,
// with a scoreboard of expected shifts and a reference model of exp_acc/overflow.
module tb_bfp_shift_ctrl;
  localparam int DW = 20;
  localparam int OW = 10;
  localparam int LW = 10;
  localparam int EW = 8;

  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  bfp_shift_ctrl_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .EXP_WIDTH(EW)) bus ();

  bfp_shift_ctrl #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .LEN_WIDTH(LW), .EXP_WIDTH(EW)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  typedef struct { int sh; bit ov; } exp_t;
  typedef struct { int len; int n; logic [DW-1:0] smp[4]; int sh; bit ov; } vec_t;

  exp_t           sbq[$];
  exp_t           mon_e;
  vec_t           tbl[11];
  logic [DW-1:0]  sbuf[$];
  int             compared = 0;
  int             mismatched = 0;
  int             m_exp = 0;
  bit             m_ovf = 0;
  bit             pend = 0;
  int             pend_sh = 0;
  bit             pend_ov = 0;

  task automatic chk(input string name, input integer act, input integer req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: round-half-up division by 2^s, smallest s that fits in OW bits.
  function automatic int model_shift(input longint pk, output bit ov);
    longint r;
    for (int s = 0; s <= 10; s++) begin
      r = (s == 0) ? pk : ((pk + (longint'(1) << (s - 1))) >> s);
      if (r <= longint'((1 << OW) - 1)) begin
        ov = 1'b0;
        return s;
      end
    end
    ov = 1'b1;
    return 10;
  endfunction

  always @(negedge clk) begin
    if (rst_b && bus.shift_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_shift_valid", 1, 0);
      end else begin
        mon_e = sbq.pop_front();
        chk("shift_bit", bus.shift_bit, mon_e.sh);
        pend    = 1'b1;
        pend_sh = mon_e.sh;
        pend_ov = mon_e.ov;
      end
    end
  end

  always @(posedge clk) begin
    if (rst_b) begin
      if (pend) begin
        m_exp = bus.exp_clear ? pend_sh : ((m_exp + pend_sh > 255) ? 255 : m_exp + pend_sh);
        m_ovf = bus.exp_clear ? pend_ov : (m_ovf | pend_ov);
        pend  = 1'b0;
      end else if (bus.exp_clear) begin
        m_exp = 0;
        m_ovf = 1'b0;
      end
    end
  end

  // Runs one block from sbuf; returns at the negedge inside the shift_valid cycle.
  task automatic send_block(input int len_field, input bit gaps, input int esh, input bit eov);
    exp_t e;
    e.sh = esh;
    e.ov = eov;
    sbq.push_back(e);
    bus.block_len   = len_field[LW-1:0];
    bus.block_start = 1'b1;
    @(posedge clk); #1;
    bus.block_start = 1'b0;
    foreach (sbuf[i]) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.data_valid  = 1'b0;
          bus.data_in     = DW'($urandom);
          bus.block_start = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
          bus.block_start = 1'b0;
        end
      end
      bus.data_valid = 1'b1;
      bus.data_in    = sbuf[i];
      @(posedge clk); #1;
    end
    bus.data_valid = 1'b0;
    @(negedge clk);
    chk("calc_busy", bus.busy, 1);
    chk("calc_no_valid", bus.shift_valid, 0);
    @(negedge clk);
    chk("pipe_no_valid", bus.shift_valid, 0);
    chk("pipe_idle", bus.busy, 0);
    @(negedge clk);
    chk("valid_latency", bus.shift_valid, 1);
  endtask

  task automatic check_status();
    @(negedge clk);
    chk("exp_acc", bus.exp_acc, m_exp);
    chk("overflow", bus.overflow, m_ovf);
  endtask

  task automatic model_reset();
    sbq.delete();
    pend  = 1'b0;
    m_exp = 0;
    m_ovf = 1'b0;
  endtask

  initial begin
    int  sh;
    bit  ov;
    logic [DW-1:0] pk;

    bus.block_start = 1'b0;
    bus.block_len   = '0;
    bus.data_valid  = 1'b0;
    bus.data_in     = '0;
    bus.exp_clear   = 1'b0;
    rst_b           = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_b = 1'b1;
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_shift_valid", bus.shift_valid, 0);
    chk("rst_shift_bit", bus.shift_bit, 0);
    chk("rst_exp_acc", bus.exp_acc, 0);
    chk("rst_overflow", bus.overflow, 0);

    tbl[0]  = '{4, 4, '{20'd100, 20'd1023, 20'd7, 20'd0}, 0, 1'b0};
    tbl[1]  = '{2, 2, '{20'd1024, 20'd3, 20'd0, 20'd0}, 1, 1'b0};
    tbl[2]  = '{1, 1, '{20'd2047, 20'd0, 20'd0, 20'd0}, 2, 1'b0};
    tbl[3]  = '{1, 1, '{20'hFFFFF, 20'd0, 20'd0, 20'd0}, 10, 1'b1};
    tbl[4]  = '{3, 3, '{20'd0, 20'd0, 20'd0, 20'd0}, 0, 1'b0};
    tbl[5]  = '{1, 1, '{20'd1023, 20'd0, 20'd0, 20'd0}, 0, 1'b0};
    tbl[6]  = '{1, 1, '{20'd1024, 20'd0, 20'd0, 20'd0}, 1, 1'b0};
    tbl[7]  = '{2, 2, '{20'd2046, 20'd5, 20'd0, 20'd0}, 1, 1'b0};
    tbl[8]  = '{1, 1, '{20'd2045, 20'd0, 20'd0, 20'd0}, 1, 1'b0};
    tbl[9]  = '{1, 1, '{20'hFFDFF, 20'd0, 20'd0, 20'd0}, 10, 1'b0};
    tbl[10] = '{1, 1, '{20'hFFE00, 20'd0, 20'd0, 20'd0}, 10, 1'b1};

    foreach (tbl[k]) begin
      sbuf.delete();
      for (int j = 0; j < tbl[k].n; j++) sbuf.push_back(tbl[k].smp[j]);
      send_block(tbl[k].len, 1'b0, tbl[k].sh, tbl[k].ov);
      check_status();
    end

    bus.exp_clear = 1'b1;
    @(posedge clk); #1;
    bus.exp_clear = 1'b0;
    check_status();
    chk("clear_exp_acc", bus.exp_acc, 0);
    chk("clear_overflow", bus.overflow, 0);

    // gapped stream with stray block_start pulses and junk data while data_valid is low
    for (int r = 0; r < 3; r++) begin
      sbuf.delete();
      pk = '0;
      for (int j = 0; j < 5; j++) begin
        sbuf.push_back(DW'($urandom_range(0, 20'hFFFFF) >> $urandom_range(0, 12)));
        if (sbuf[j] > pk) pk = sbuf[j];
      end
      sh = model_shift(longint'(pk), ov);
      send_block(5, 1'b1, sh, ov);
      check_status();
    end

    // block_len of 0 runs 1024 samples
    sbuf.delete();
    for (int j = 0; j < 1024; j++) sbuf.push_back(DW'($urandom_range(0, 900)));
    sbuf[500] = 20'd3000;
    sh = model_shift(longint'(3000), ov);
    send_block(0, 1'b0, sh, ov);
    check_status();

    // back-to-back overflow blocks: exp_acc saturates
    sbuf.delete();
    sbuf.push_back(20'hFFFFF);
    for (int r = 0; r < 30; r++) send_block(1, 1'b0, 10, 1'b1);
    check_status();
    chk("sat_exp_acc", bus.exp_acc, 255);
    chk("sat_overflow", bus.overflow, 1);

    // clear coincident with a shift of 3
    sbuf.delete();
    sbuf.push_back(20'd8184);
    send_block(1, 1'b0, 3, 1'b0);
    bus.exp_clear = 1'b1;
    @(posedge clk); #1;
    bus.exp_clear = 1'b0;
    check_status();
    chk("coincident_exp_acc", bus.exp_acc, 3);
    chk("coincident_overflow", bus.overflow, 0);

    // reset in the middle of a block
    bus.block_len   = 10'd8;
    bus.block_start = 1'b1;
    @(posedge clk); #1;
    bus.block_start = 1'b0;
    repeat (3) begin
      bus.data_valid = 1'b1;
      bus.data_in    = 20'hFFFFF;
      @(posedge clk); #1;
    end
    bus.data_valid = 1'b0;
    @(negedge clk);
    rst_b = 1'b0;
    model_reset();
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_shift_valid", bus.shift_valid, 0);
    chk("abort_shift_bit", bus.shift_bit, 0);
    chk("abort_exp_acc", bus.exp_acc, 0);
    chk("abort_overflow", bus.overflow, 0);
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("abort_no_valid", bus.shift_valid, 0);
    end

    sbuf.delete();
    sbuf.push_back(20'd2047);
    send_block(1, 1'b0, 2, 1'b0);
    check_status();

    chk("scoreboard_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
